demux_param_n_to_w: RTL
=======================

// Module: demux_param_n_to_w
// PURPOSE
//  Parametrised narrow-to-wide lane demux for the PCI physical layer receive path.
//  Collects RATIO beats of IN_W-bit symbols, qualified by valid_in, into one OUT_W-bit word.
//  Strobes valid_out for one cycle per completed word.
//  Single clock domain: the slow clock is replaced by a qualifying strobe.
//  Sits between the byte deserializer and the word-level link logic.
// PARAMETERS
//  IN_W       8  width of one input symbol (bits)
//  RATIO      4  input beats per output word; legal range 2..16
//  OUT_W      IN_W*RATIO  output word width (derived localparam, not overridable)
//  MSB_FIRST  1  1: first beat lands in data_out[OUT_W-1 -: IN_W]; 0: first beat lands in [IN_W-1:0]
// PORTS
//  clk_4f      in   1                fast symbol clock; all logic on its rising edge
//  reset       in   1                synchronous, active-high reset
//  valid_in    in   1                data_in holds a valid symbol this cycle
//  data_in     in   IN_W             input symbol
//  align       in   1                synchronous lane re-alignment; forces next accepted beat to lane 0
//  data_out    out  OUT_W            last completed word (registered)
//  valid_out   out  1                one-cycle pulse: data_out was updated this cycle
//  lane_idx    out  $clog2(RATIO)    index of the lane the next accepted beat fills
//  parity_out  out  1                even-parity bit of data_out (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (sync, highest priority): data_out=0, valid_out=0, lane_idx=0, partial accumulator=0, parity_out=0.
//  - Beat accept: at posedge clk_4f with valid_in=1, data_in is written into lane lane_idx of the accumulator.
//    lane_idx then increments. No backpressure: every valid beat is taken.
//  - Gaps: valid_in=0 holds lane_idx and the accumulator unchanged; gaps of any length are legal.
//  - Completion: when the accepted beat is lane RATIO-1:
//    * data_out <= {accumulated lanes, data_in}, placed per MSB_FIRST.
//    * valid_out=1 for exactly that following cycle.
//    * lane_idx wraps to 0.
//    Latency is 1 clk from the last beat's sampling edge to valid_out high.
//  - valid_out=0 in every other cycle. data_out holds its value until the next completion; it is never cleared except by reset.
//  - Back-to-back words: minimum valid_out spacing is RATIO cycles. valid_out never asserts on consecutive cycles.
//  - align=1 (sync): the partial accumulator is discarded and lane_idx is forced to 0.
//    * align with valid_in=1 in the same cycle: data_in is taken as lane 0 and lane_idx becomes 1.
//    * align has no effect on data_out or valid_out.
//    * A completion in the same cycle as align is suppressed: align wins.
//  - Reset mid-word: the partial word is dropped. The first valid beat after reset is lane 0.
//  - Lane counter: a 0..RATIO-1 wrap-around counter. There is no overflow state.
//  - Internal registers: accumulator (OUT_W-IN_W bits), lane counter, output registers. No FSM beyond the lane counter.
// CONFIGURATION
//  DEMUX_PARITY_EN defined:
//    parity_out is registered alongside data_out and equals ^word for the completed word.
//    It updates only on completion and is valid while valid_out=1.
//  DEMUX_PARITY_EN undefined:
//    parity_out is tied to 0 and no parity logic is synthesised.
//    All other behaviour is identical.
// TESTING (defaults IN_W=8, RATIO=4, MSB_FIRST=1 unless stated)
//  1. reset held 3 clk with random data_in/valid_in -> data_out=0, valid_out=0, lane_idx=0 throughout.
//  2. Contiguous beats EE,FF,FD,CC -> one valid_out pulse 1 clk after CC; data_out=32'hEEFFFDCC.
//     With DEMUX_PARITY_EN, parity_out=1 (popcount 25).
//  3. Beats AA,(gap),12,(gap,gap),BB,34 -> single pulse after 34; data_out=32'hAA12BB34; no pulse during gaps.
//  4. Beats 11,22, then align=1 with valid 33, then 44,55,66 -> data_out=32'h33445566; 11/22 never appear.
//  5. Beats 01,02, reset 1 clk, then 03,04,05,06 -> data_out=0 after reset, then 32'h03040506.
//  6. MSB_FIRST=0, RATIO=2, IN_W=16: beats BEEF,CAFE -> data_out=32'hCAFEBEEF.
//     Continuous stream -> pulses exactly every 2 clk.

Source files
------------

// File: rtl/demux_param_n_to_w_if.sv
// Bus bundle for demux_param_n_to_w: input symbol stream plus word-level outputs.
// master drives the symbol side; slave is the demux itself.
interface demux_param_n_to_w_if #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int LW    = $clog2(RATIO);

    logic             valid_in;
    logic [IN_W-1:0]  data_in;
    logic             align;
    logic [OUT_W-1:0] data_out;
    logic             valid_out;
    logic [LW-1:0]    lane_idx;
    logic             parity_out;

    modport master (
        output valid_in, data_in, align,
        input  data_out, valid_out, lane_idx, parity_out
    );

    modport slave (
        input  valid_in, data_in, align,
        output data_out, valid_out, lane_idx, parity_out
    );
endinterface

// File: rtl/demux_param_n_to_w.sv
// Narrow-to-wide lane demux: packs RATIO qualified IN_W-bit beats into one OUT_W-bit word.
// Optional feature macro DEMUX_PARITY_EN registers even parity of each completed word.
module demux_param_n_to_w #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk_4f,
    input  logic                 reset,
    demux_param_n_to_w_if.slave  bus
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int ACC_W = OUT_W - IN_W;
    localparam int LW    = $clog2(RATIO);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [OUT_W-1:0] data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;
    logic [OUT_W-1:0] word;
`ifdef DEMUX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Accumulator holds lanes 0..RATIO-2 in arrival order; the final lane comes straight from data_in.
    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < RATIO - 1; i++) begin
            if (MSB_FIRST != 0) word[(RATIO-1-i)*IN_W +: IN_W] = acc_q[i*IN_W +: IN_W];
            else                word[i*IN_W +: IN_W]           = acc_q[i*IN_W +: IN_W];
        end
        if (MSB_FIRST != 0) word[IN_W-1:0]        = bus.data_in;
        else                word[OUT_W-1 -: IN_W] = bus.data_in;
    end

    always_comb begin
        acc_d       = acc_q;
        lane_d      = lane_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
`ifdef DEMUX_PARITY_EN
        parity_d    = parity_q;
`endif
        // align overrides everything, including a completion that would land this cycle
        if (bus.align) begin
            acc_d  = '0;
            lane_d = '0;
            if (bus.valid_in) begin
                acc_d[IN_W-1:0] = bus.data_in;
                lane_d          = LW'(1);
            end
        end else if (bus.valid_in) begin
            if (lane_q == LW'(RATIO - 1)) begin
                data_out_d  = word;
                valid_out_d = 1'b1;
                lane_d      = '0;
                acc_d       = '0;
`ifdef DEMUX_PARITY_EN
                parity_d    = ^word;
`endif
            end else begin
                for (int unsigned i = 0; i < RATIO - 1; i++) begin
                    if (lane_q == LW'(i)) acc_d[i*IN_W +: IN_W] = bus.data_in;
                end
                lane_d = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            acc_q       <= '0;
            lane_q      <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
`ifdef DEMUX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            acc_q       <= acc_d;
            lane_q      <= lane_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
`ifdef DEMUX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.lane_idx  = lane_q;
`ifdef DEMUX_PARITY_EN
    assign bus.parity_out = parity_q;
`else
    assign bus.parity_out = 1'b0;
`endif
endmodule
